// File: rtl/qspi_mem_arbiter_pkg.sv
// Shared types and helpers for the QSPI XIP memory-port arbiter.
package qspi_mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;
  localparam int DEF_AW  = 24;
  localparam int DEF_DW  = 32;

  // Input is assumed one-hot (or zero); OR-folding the set positions avoids a priority chain.
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/qspi_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of r searching from ptr upward, modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  r,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  logic found;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (!found && r[j]) begin
        found     = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = IW'(j);
      end
    end
    win_vld = found;
  end

endmodule

// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter sharing the QSPI XIP memory port among Wishbone-classic requesters.
// Optional watchdog abort enabled by defining QSPI_MEM_ARB_TIMEOUT_EN.
module qspi_mem_arbiter
  import qspi_mem_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int AW      = DEF_AW,
  parameter  int DW      = DEF_DW,
  parameter  int TIMEOUT = 1024,
  localparam int SW      = DW / 8,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    en_i,
  input  logic [N_REQ-1:0]    req_cyc_i,
  input  logic [N_REQ-1:0]    req_stb_i,
  input  logic [N_REQ-1:0]    req_we_i,
  input  logic [N_REQ*AW-1:0] req_adr_i,
  input  logic [N_REQ*DW-1:0] req_dat_i,
  input  logic [N_REQ*SW-1:0] req_sel_i,
  output logic [N_REQ-1:0]    req_ack_o,
  output logic [N_REQ-1:0]    req_err_o,
  output logic [DW-1:0]       req_dat_o,
  output logic                mem_cyc_o,
  output logic                mem_stb_o,
  output logic                mem_we_o,
  output logic [AW-1:0]       mem_adr_o,
  output logic [DW-1:0]       mem_dat_o,
  output logic [SW-1:0]       mem_sel_o,
  input  logic                mem_ack_i,
  input  logic [DW-1:0]       mem_dat_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic                busy_o
);

  arb_state_e       state_q;
  logic [IW-1:0]    ptr_q;
  logic [N_REQ-1:0] r;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [IW-1:0]    nxt_ptr;
  logic [IW-1:0]    g;
  logic             in_busy;
  logic             wd_fire;

  assign r       = req_cyc_i & req_stb_i & en_i;
  assign in_busy = (state_q == BUSY);
  assign g       = IW'(onehot2idx(MAX_REQ'(gnt_o)));
  assign nxt_ptr = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .r       (r),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // en_i only gates new grants; an in-flight transaction ends on ack, abort or watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_o   <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= BUSY;
            gnt_o   <= pick_oh;
            ptr_q   <= nxt_ptr;
            busy_o  <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ack_i || !req_cyc_i[g] || wd_fire) begin
            state_q <= IDLE;
            gnt_o   <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_o   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_cyc_o = in_busy & req_cyc_i[g] & req_stb_i[g];
    mem_stb_o = mem_cyc_o;
    mem_we_o  = in_busy & req_we_i[g];
    mem_adr_o = in_busy ? req_adr_i[g*AW +: AW] : '0;
    mem_dat_o = in_busy ? req_dat_i[g*DW +: DW] : '0;
    mem_sel_o = in_busy ? req_sel_i[g*SW +: SW] : '0;
    req_ack_o = gnt_o & {N_REQ{in_busy & mem_ack_i}};
    req_err_o = gnt_o & {N_REQ{wd_fire}};
    req_dat_o = in_busy ? mem_dat_i : '0;
  end

`ifdef QSPI_MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wd_cnt;

  // Held at zero outside BUSY, so the first BUSY cycle always counts from 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || !in_busy) wd_cnt <= '0;
    else                   wd_cnt <= wd_cnt + CW'(1);
  end

  assign wd_fire = in_busy & ~mem_ack_i & (wd_cnt == CW'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Scenario bench for qspi_mem_arbiter: grant order, ack routing, abort, reset, optional watchdog.
module tb_qspi_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    en_i;
  logic [N-1:0]    req_cyc_i, req_stb_i, req_we_i;
  logic [N*AW-1:0] req_adr_i;
  logic [N*DW-1:0] req_dat_i;
  logic [N*SW-1:0] req_sel_i;
  logic [N-1:0]    req_ack_o, req_err_o;
  logic [DW-1:0]   req_dat_o;
  logic            mem_cyc_o, mem_stb_o, mem_we_o;
  logic [AW-1:0]   mem_adr_o;
  logic [DW-1:0]   mem_dat_o;
  logic [SW-1:0]   mem_sel_o;
  logic            mem_ack_i;
  logic [DW-1:0]   mem_dat_i;
  logic [N-1:0]    gnt_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [AW-1:0] adr;
  } exp_t;

  exp_t        gq[$];
  logic [31:0] dq[$];

  qspi_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o),
    .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [AW-1:0] adr_of(input int k);
    return 24'h000100 + 24'(k) * 24'h000010;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    en_i = '0; req_cyc_i = '0; req_stb_i = '0; req_we_i = '0;
    req_sel_i = '1; mem_ack_i = 1'b0; mem_dat_i = '0;
    for (int k = 0; k < N; k++) begin
      req_adr_i[k*AW +: AW] = adr_of(k);
      req_dat_i[k*DW +: DW] = 32'h5500_0000 | 32'(k);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    en_i = '1; req_cyc_i = '1; req_stb_i = '1; req_we_i = '1;
    mem_ack_i = 1'b1; mem_dat_i = 32'hFFFF_FFFF;
    step(); step(); #1;
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if ({mem_cyc_o, mem_stb_o, mem_we_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {mem_cyc_o, mem_stb_o, mem_we_o}); end
    checks++; if ({mem_adr_o, mem_dat_o, mem_sel_o} !== '0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_adr_o, mem_dat_o, mem_sel_o}); end
    checks++; if ({req_ack_o, req_err_o} !== 8'h00) begin errors++; $display("FAIL reset_ack_err: got %b want 0", {req_ack_o, req_err_o}); end
    checks++; if (req_dat_o !== 32'h0) begin errors++; $display("FAIL reset_req_dat: got %h want 0", req_dat_o); end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    en_i = 4'b0001;
    req_adr_i[0 +: AW] = 24'h000100;
    req_cyc_i[0] = 1'b1; req_stb_i[0] = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_latency: busy got %b want 0", busy_o); end
    step(); #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt_o); end
    checks++; if (mem_cyc_o !== 1'b1 || mem_adr_o !== 24'h000100) begin errors++; $display("FAIL single_mem: cyc %b adr %h want 1 000100", mem_cyc_o, mem_adr_o); end
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      checks++; if (req_ack_o !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b want 0000", req_ack_o); end
    end
    step();
    mem_ack_i = 1'b1; mem_dat_i = 32'hDEADBEEF;
    dq.push_back(32'hDEADBEEF);
    #1;
    checks++; if (req_ack_o !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", req_ack_o); end
    begin
      logic [31:0] ed;
      ed = dq.pop_front();
      checks++; if (req_dat_o !== ed) begin errors++; $display("FAIL single_dat: got %h want %h", req_dat_o, ed); end
    end
    step();
    mem_ack_i = 1'b0; req_cyc_i = '0; req_stb_i = '0;
    #1;
    checks++; if (busy_o !== 1'b0 || mem_cyc_o !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b cyc %b want 0 0", busy_o, mem_cyc_o); end
  endtask

  task automatic test_fairness();
    int   gap, grants;
    exp_t e;
    do_reset();
    en_i = 4'hF; req_cyc_i = 4'hF; req_stb_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e.gnt = 4'(1 << (k % N));
      e.adr = adr_of(k % N);
      gq.push_back(e);
    end
    gap = 0; grants = 0;
    for (int c = 0; c < 40 && gq.size() > 0; c++) begin
      step();
      mem_ack_i = 1'b0;
      #1;
      if (mem_cyc_o) begin
        e = gq.pop_front();
        checks++; if (gnt_o !== e.gnt || mem_adr_o !== e.adr) begin errors++; $display("FAIL fair_order: gnt %b adr %h want %b %h", gnt_o, mem_adr_o, e.gnt, e.adr); end
        if (grants > 0) begin
          checks++; if (gap !== 1) begin errors++; $display("FAIL fair_gap: got %0d want 1", gap); end
        end
        grants++; gap = 0;
        mem_ack_i = 1'b1;
        #1;
        checks++; if (req_ack_o !== e.gnt) begin errors++; $display("FAIL fair_ack: got %b want %b", req_ack_o, e.gnt); end
      end else if (grants > 0) gap++;
    end
    checks++; if (gq.size() != 0) begin errors++; $display("FAIL fair_timeout: %0d grants missing want 0", gq.size()); end
    gq.delete();
  endtask

  task automatic test_enable();
    int   bad_ack;
    exp_t e;
    do_reset();
    en_i = 4'b1010; req_cyc_i = 4'hF; req_stb_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      e.gnt = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      e.adr = adr_of((k % 2 == 0) ? 1 : 3);
      gq.push_back(e);
    end
    bad_ack = 0;
    for (int c = 0; c < 30 && gq.size() > 0; c++) begin
      step();
      mem_ack_i = 1'b0;
      #1;
      if (mem_cyc_o) begin
        e = gq.pop_front();
        checks++; if (gnt_o !== e.gnt || mem_adr_o !== e.adr) begin errors++; $display("FAIL enable_order: gnt %b adr %h want %b %h", gnt_o, mem_adr_o, e.gnt, e.adr); end
        mem_ack_i = 1'b1;
        #1;
      end
      if (req_ack_o[0] !== 1'b0 || req_ack_o[2] !== 1'b0) bad_ack++;
    end
    checks++; if (bad_ack !== 0) begin errors++; $display("FAIL enable_masked_ack: got %0d cycles want 0", bad_ack); end
    checks++; if (gq.size() != 0) begin errors++; $display("FAIL enable_timeout: %0d grants missing want 0", gq.size()); end
    gq.delete();
  endtask

  task automatic test_abort();
    do_reset();
    en_i = 4'hF; req_cyc_i[2] = 1'b1; req_stb_i[2] = 1'b1;
    step(); #1;
    checks++; if (gnt_o !== 4'b0100 || busy_o !== 1'b1) begin errors++; $display("FAIL abort_gnt: gnt %b busy %b want 0100 1", gnt_o, busy_o); end
    step();
    req_cyc_i[2] = 1'b0; req_stb_i[2] = 1'b0;
    #1;
    checks++; if (mem_cyc_o !== 1'b0) begin errors++; $display("FAIL abort_cyc: got %b want 0", mem_cyc_o); end
    step();
    mem_ack_i = 1'b1; mem_dat_i = 32'h1234_5678;
    #1;
    checks++; if (busy_o !== 1'b0 || gnt_o !== 4'b0000) begin errors++; $display("FAIL abort_idle: busy %b gnt %b want 0 0000", busy_o, gnt_o); end
    checks++; if (req_ack_o !== 4'b0000 || req_dat_o !== 32'h0) begin errors++; $display("FAIL abort_late_ack: ack %b dat %h want 0000 0", req_ack_o, req_dat_o); end
    step();
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset_wrap();
    do_reset();
    en_i = 4'hF; req_cyc_i[3] = 1'b1; req_stb_i[3] = 1'b1;
    step(); #1;
    checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b want 1000", gnt_o); end
    step();
    rst_i = 1'b1;
    step(); #1;
    checks++; if ({gnt_o, busy_o, mem_cyc_o, req_ack_o} !== '0 || mem_adr_o !== '0) begin errors++; $display("FAIL wrap_midreset: gnt %b busy %b cyc %b adr %h want 0", gnt_o, busy_o, mem_cyc_o, mem_adr_o); end
    rst_i = 1'b0;
    req_cyc_i[0] = 1'b1; req_stb_i[0] = 1'b1;
    step(); #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL wrap_ptr0: got %b want 0001", gnt_o); end
  endtask

`ifdef QSPI_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      en_i = 4'hF; req_cyc_i[1] = 1'b1; req_stb_i[1] = 1'b1;
      early = 0;
      for (int c = 1; c <= 16; c++) begin
        step();
        mem_ack_i = (pass == 1 && c == 16);
        #1;
        if (c < 16 && (req_err_o !== 4'b0000 || busy_o !== 1'b1)) early++;
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL wd_early: got %0d bad cycles want 0", early); end
      if (pass == 0) begin
        checks++; if (req_err_o !== 4'b0010 || req_ack_o !== 4'b0000) begin errors++; $display("FAIL wd_fire: err %b ack %b want 0010 0000", req_err_o, req_ack_o); end
      end else begin
        checks++; if (req_err_o !== 4'b0000 || req_ack_o !== 4'b0010) begin errors++; $display("FAIL wd_ack_wins: err %b ack %b want 0000 0010", req_err_o, req_ack_o); end
      end
      step();
      mem_ack_i = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0 || mem_cyc_o !== 1'b0 || req_err_o !== 4'b0000) begin errors++; $display("FAIL wd_idle: busy %b cyc %b err %b want 0 0 0000", busy_o, mem_cyc_o, req_err_o); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_enable();
    test_abort();
    test_reset_wrap();
`ifdef QSPI_MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
